psk_stream_modulator: RTL
=========================

# psk_stream_modulator

Parametrised successor to the team's per-word BPSK inverter. It accepts an N-bit codeword over a valid/ready handshake: 7 bits for Hamming, 15 for BCH. It serialises the codeword MSB-first into signed baseband symbols, one symbol per clock, in BPSK or QPSK with optional differential encoding. It sits between the channel encoder (Hamming/BCH) and the channel/noise model.

## Interface
- N, default 7: codeword width; use 15 for BCH. Legal range 2..32.
- AMP_W, default 8: signed symbol output width.
- AMP, default 127: symbol magnitude. Must satisfy 1 <= AMP <= 2^(AMP_W-1)-1.

- CLK  in  1  rising-edge clock; the only clock.
- RST_N  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- DataIn  in  N  codeword; bit N-1 is transmitted first.
- InValid  in  1  DataIn, Mode, Flag and DiffEn are valid.
- InReady  out  1  block accepts a word on this cycle when InValid is also high.
- Mode  in  1  0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol).
- Flag  in  1  polarity: 1 = bits pass unchanged, 0 = bits inverted.
- DiffEn  in  1  1 = differential encoding enabled.
- SymI  out  AMP_W  signed in-phase symbol.
- SymQ  out  AMP_W  signed quadrature symbol.
- SymValid  out  1  SymI and SymQ hold a symbol this cycle.
- SymLast  out  1  final symbol of the current codeword; only asserted while SymValid is high.
- Busy  out  1  a codeword is being transmitted.

## Operation
- FSM states: IDLE and SEND.
- **IDLE:**
  - InReady = 1.
  - An accept (InValid & InReady) captures DataIn into a shift register.
  - The same accept captures Mode, Flag and DiffEn; these settings hold for the whole word.
  - Also loads the symbol counter with S, where S = N for BPSK and S = ceil(N/2) for QPSK.
  - Clears the differential history registers pI and pQ to 0.
  - Next state: SEND.
- **SEND:** emits one symbol per cycle.
  - Counter decrements each cycle.
  - On the last symbol (counter = 1), InReady = 1.
  - An accept on that cycle reloads the word and stays in SEND, so there is no gap between words.
  - With no accept on that cycle, next state is IDLE.
  - InReady = 0 on every other SEND cycle.
- **Bit path,** per raw bit b:
  - Polarity: p = Flag ? b : ~b.
  - If DiffEn = 1: d = p XOR prev, and prev is updated to d. Otherwise d = p.
  - Mapping: d = 1 gives +AMP, d = 0 gives -AMP.
- **BPSK:** one bit per symbol, mapped onto SymI; SymQ = 0. The differential history uses pI only.
- **QPSK:**
  - Each symbol takes two bits, MSB-first: the first bit goes to the I rail, the second to the Q rail.
  - Each rail keeps its own differential history (pI, pQ).
  - If N is odd, the final Q bit is padded with raw 0, which still passes through the polarity and differential stages.
- **Output gating:** whenever SymValid = 0, SymI = SymQ = 0 and SymLast = 0.
- Busy = 1 exactly while in SEND.
- Symbol outputs have no backpressure. The downstream consumer must take one symbol per cycle.

## Timing
- **Reset** (RST_N low at a rising edge):
  - Next state is IDLE.
  - SymI = SymQ = 0; SymValid, SymLast and Busy = 0.
  - pI = pQ = 0; the counter is cleared.
  - InReady is forced to 0 while RST_N is low.
- **Reset mid-word:** the word is aborted. No SymLast is issued for it, and the first cycle after reset deasserts shows IDLE with InReady = 1.
- **Latency:** all symbol outputs are registered. For an accept at edge k, the first symbol is valid on the cycle after edge k+1.
- A word occupies exactly S consecutive SymValid cycles. SymLast is high on the S-th of them.
- **Back-to-back:** an accept on the SymLast cycle makes the next word's first symbol follow immediately, with no idle cycle. Differential history is reset at the word boundary.
- **Ignored inputs:** InValid while InReady = 0 has no effect. Mode, Flag and DiffEn changes mid-word are ignored.
- **Arithmetic:** -AMP is formed as a two's-complement value in AMP_W bits. There is no overflow, by the constraint on AMP.

## Test plan
- **BPSK, plain:** N=7, AMP=127, DataIn=7'b1011001, Mode=0, Flag=1, DiffEn=0 -> SymI = +127,-127,+127,+127,-127,-127,+127; SymQ = 0 throughout; SymValid high for 7 cycles; SymLast on the 7th.
- **BPSK, inverted:** same word with Flag=0 -> SymI sequence is the exact negation of the plain case (-127,+127,-127,-127,+127,+127,-127).
- **QPSK, odd N:** DataIn=7'b1011001, Mode=1, Flag=1 -> 4 symbols.
  - SymI = +127,+127,-127,+127.
  - SymQ = -127,+127,-127,-127 (last Q is the padded bit).
  - SymLast on the 4th symbol.
- **Differential BPSK:** DataIn=7'b1111111, Flag=1, DiffEn=1 -> SymI = +127,-127,+127,-127,+127,-127,+127.
- **Back-to-back, BCH width:** N=15, InValid held high for two words -> 30 contiguous SymValid cycles; SymLast on cycles 15 and 30; InReady high only on those cycles after the first accept.
- **Reset mid-word:** RST_N low during the 3rd symbol.
  - Next cycle: SymValid = 0, SymI = SymQ = 0, Busy = 0, no SymLast.
  - After release: InReady = 1.
  - The next word starts with fresh differential history.

Source files
------------

// File: rtl/psk_stream_modulator.sv
// psk_stream_modulator: serialises an N-bit codeword MSB-first into signed
// BPSK/QPSK baseband symbols, one per clock, with optional differential coding.
module psk_stream_modulator #(
    parameter int N     = 7,
    parameter int AMP_W = 8,
    parameter int AMP   = 127
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     DataIn,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Mode,
    input  logic             Flag,
    input  logic             DiffEn,
    output logic [AMP_W-1:0] SymI,
    output logic [AMP_W-1:0] SymQ,
    output logic             SymValid,
    output logic             SymLast,
    output logic             Busy
);

    localparam int               CNT_W   = $clog2(N + 1);
    localparam logic [CNT_W-1:0] S_BPSK  = CNT_W'(N);
    localparam logic [CNT_W-1:0] S_QPSK  = CNT_W'((N + 1) / 2);
    localparam logic [AMP_W-1:0] AMP_POS = AMP_W'(AMP);
    localparam logic [AMP_W-1:0] AMP_NEG = AMP_W'(-AMP);

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_nxt;

    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             mode_r, flag_r, diff_r;
    logic             p_i, p_q;

    logic             last_slot, accept, take_new, emit;
    logic [CNT_W-1:0] s_new, cnt_emit;
    logic [N-1:0]     src_word, src_shift;
    logic             src_mode, src_flag, src_diff, src_pi, src_pq;
    logic             b_i, b_q, d_i, d_q;

    always_ff @(posedge CLK) begin
        // NOTE: registered state is always written with <= so every flop
        // samples pre-edge values and simulation order cannot matter.
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // cnt counts symbols not yet emitted; cnt == 0 in SEND is the SymLast
    // cycle, where a new word may be taken without a gap.
    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and
        // no latch is inferred.
        state_nxt = state;
        last_slot = (state == SEND) && (cnt == '0);
        InReady   = RST_N && ((state == IDLE) || last_slot);
        accept    = InValid && InReady;
        take_new  = last_slot && accept;
        emit      = (state == SEND) && ((cnt != '0) || accept);
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (last_slot && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A back-to-back accept feeds the first symbol straight from the inputs
    // with fresh differential history.
    always_comb begin
        s_new     = Mode ? S_QPSK : S_BPSK;
        src_word  = take_new ? DataIn : shreg;
        src_mode  = take_new ? Mode   : mode_r;
        src_flag  = take_new ? Flag   : flag_r;
        src_diff  = take_new ? DiffEn : diff_r;
        src_pi    = take_new ? 1'b0   : p_i;
        src_pq    = take_new ? 1'b0   : p_q;
        cnt_emit  = take_new ? (s_new - CNT_W'(1)) : (cnt - CNT_W'(1));
        b_i       = src_word[N-1];
        b_q       = src_mode ? src_word[N-2] : 1'b0;
        d_i       = (src_flag ? b_i : ~b_i) ^ (src_diff & src_pi);
        d_q       = (src_flag ? b_q : ~b_q) ^ (src_diff & src_pq);
        src_shift = src_mode ? (src_word << 2) : (src_word << 1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shreg    <= '0;
            cnt      <= '0;
            mode_r   <= 1'b0;
            flag_r   <= 1'b0;
            diff_r   <= 1'b0;
            p_i      <= 1'b0;
            p_q      <= 1'b0;
            SymI     <= '0;
            SymQ     <= '0;
            SymValid <= 1'b0;
            SymLast  <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) begin
                shreg  <= DataIn;
                cnt    <= s_new;
                mode_r <= Mode;
                flag_r <= Flag;
                diff_r <= DiffEn;
                p_i    <= 1'b0;
                p_q    <= 1'b0;
            end else if (emit) begin
                shreg <= src_shift;
                cnt   <= cnt_emit;
                if (take_new) begin
                    mode_r <= Mode;
                    flag_r <= Flag;
                    diff_r <= DiffEn;
                end
                p_i <= src_diff ? d_i : 1'b0;
                p_q <= (src_diff && src_mode) ? d_q : 1'b0;
            end
            SymValid <= emit;
            SymLast  <= emit && (cnt_emit == '0);
            SymI     <= emit ? (d_i ? AMP_POS : AMP_NEG) : '0;
            SymQ     <= (emit && src_mode) ? (d_q ? AMP_POS : AMP_NEG) : '0;
        end
    end

    assign Busy = (state == SEND);

endmodule
